// File: rtl/pe_chk_pkg.sv
// Shared constants, state encoding and latency lookup for the PE result checker.
package pe_chk_pkg;

  localparam int unsigned CODE_W  = 16;
  localparam int unsigned LAT_W   = 3;
  localparam int unsigned ERR_W   = 8;
  localparam int unsigned MAX_LAT = 6;

  localparam logic [CODE_W-1:0] F1 = CODE_W'(1);
  localparam logic [CODE_W-1:0] F2 = CODE_W'(2);
  localparam logic [CODE_W-1:0] F3 = CODE_W'(3);
  localparam logic [CODE_W-1:0] F4 = CODE_W'(4);
  localparam logic [CODE_W-1:0] F5 = CODE_W'(5);
  localparam logic [CODE_W-1:0] F6 = CODE_W'(6);
  localparam logic [CODE_W-1:0] F7 = CODE_W'(7);
  localparam logic [CODE_W-1:0] F8 = CODE_W'(8);

  localparam logic [LAT_W-1:0] LAT_F1 = LAT_W'(2);
  localparam logic [LAT_W-1:0] LAT_F2 = LAT_W'(4);
  localparam logic [LAT_W-1:0] LAT_F3 = LAT_W'(2);
  localparam logic [LAT_W-1:0] LAT_F4 = LAT_W'(2);
  localparam logic [LAT_W-1:0] LAT_F5 = LAT_W'(2);
  localparam logic [LAT_W-1:0] LAT_F6 = LAT_W'(2);
  localparam logic [LAT_W-1:0] LAT_F7 = LAT_W'(4);
  localparam logic [LAT_W-1:0] LAT_F8 = LAT_W'(6);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_CHECK,
    ST_DONE
  } state_t;

  // Pipeline latency of a function code; 0 marks an unsupported code.
  function automatic logic [LAT_W-1:0] lat_of(input logic [CODE_W-1:0] code);
    case (code)
      F1:      return LAT_F1;
      F2:      return LAT_F2;
      F3:      return LAT_F3;
      F4:      return LAT_F4;
      F5:      return LAT_F5;
      F6:      return LAT_F6;
      F7:      return LAT_F7;
      F8:      return LAT_F8;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pe_golden_model.sv
// Reference model of PE functions 1-8: history/accumulator state plus the
// expected result for the sample currently on the inputs.
module pe_golden_model
  import pe_chk_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              sample,
  input  logic [CODE_W-1:0] code,
  input  logic [DW-1:0]     d1,
  input  logic [DW-1:0]     d2,
  input  logic [DW-1:0]     d3,
  output logic [DW-1:0]     exp_c
);

  logic [DW-1:0] x1_q;
  logic [DW-1:0] x2_q;
  logic [DW-1:0] acc_q;
  logic [DW-1:0] acc_next_c;

  always_comb begin
    acc_next_c = acc_q;
    exp_c      = '0;
    case (code)
      F1, F2: exp_c = d1;
      F3:     exp_c = d2 + d3;
      F4:     exp_c = d1 * d2;
      F5:     exp_c = d1 + d2 * d3;
      F6: begin
        acc_next_c = acc_q + d3 * DW'(7);
        exp_c      = acc_next_c;
      end
      F7:     exp_c = x2_q * x1_q + d1;
      F8: begin
        acc_next_c = acc_q + x1_q * d1;
        exp_c      = acc_next_c;
      end
      default: ;
    endcase
  end

  // x1_q/x2_q hold x[n-1]/x[n-2]; a run start wipes all history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_q  <= '0;
      x2_q  <= '0;
      acc_q <= '0;
    end else if (clear) begin
      x1_q  <= '0;
      x2_q  <= '0;
      acc_q <= '0;
    end else if (sample) begin
      x1_q  <= d1;
      x2_q  <= x1_q;
      acc_q <= acc_next_c;
    end
  end

endmodule

// File: rtl/pe_result_checker.sv
// Self-checking monitor for the PE: golden model, latency-matched delay line,
// compare window and first-error capture.
module pe_result_checker
  import pe_chk_pkg::*;
#(
  parameter int unsigned NUM_CHECKS = 16,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned DW         = 16
) (
  input  logic              Clk_In,
  input  logic              Rst_In,
  input  logic              Start,
  input  logic [CODE_W-1:0] Instruction_In,
  input  logic [DW-1:0]     D_In1,
  input  logic [DW-1:0]     D_In2,
  input  logic [DW-1:0]     D_In3,
  input  logic [DW-1:0]     D_Out,
  output logic              Busy,
  output logic              Done,
  output logic              Pass,
  output logic              Bad_Instr,
  output logic [ERR_W-1:0]  Err_Count,
  output logic [CNT_W-1:0]  First_Err_Idx,
  output logic [DW-1:0]     First_Err_Exp,
  output logic [DW-1:0]     First_Err_Got
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_CHECKS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t            state_q;
  state_t            state_next_c;
  logic [CODE_W-1:0] code_q;
  logic [LAT_W-1:0]  lat_m1_q;
  logic [LAT_W-1:0]  warm_cnt_q;
  logic [CNT_W-1:0]  chk_cnt_q;
  logic [DW-1:0]     dline_q [MAX_LAT];

  logic              code_ok_c;
  logic              start_acc_c;
  logic              sample_c;
  logic              cmp_c;
  logic              last_c;
  logic              mismatch_c;
  logic [DW-1:0]     exp_c;
  logic [DW-1:0]     exp_dly_c;
  logic [ERR_W-1:0]  err_next_c;

  pe_golden_model #(.DW(DW)) u_golden (
    .clk    (Clk_In),
    .rst_n  (Rst_In),
    .clear  (start_acc_c),
    .sample (sample_c),
    .code   (code_q),
    .d1     (D_In1),
    .d2     (D_In2),
    .d3     (D_In3),
    .exp_c  (exp_c)
  );

  assign code_ok_c  = (lat_of(Instruction_In) != '0);
  assign sample_c   = (state_q == ST_WARMUP) || (state_q == ST_CHECK);
  assign exp_dly_c  = dline_q[lat_m1_q];
  assign mismatch_c = cmp_c && (D_Out != exp_dly_c);
  assign err_next_c = (mismatch_c && (Err_Count != ERR_MAX)) ? Err_Count + ERR_W'(1) : Err_Count;

  always_ff @(posedge Clk_In or negedge Rst_In) begin
    if (!Rst_In) state_q <= ST_IDLE;
    else         state_q <= state_next_c;
  end

  // Start is honoured only when idle or done; bad codes finish immediately.
  always_comb begin
    state_next_c = state_q;
    start_acc_c  = 1'b0;
    cmp_c        = 1'b0;
    last_c       = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          start_acc_c  = 1'b1;
          state_next_c = code_ok_c ? ST_WARMUP : ST_DONE;
        end
      end
      ST_WARMUP: begin
        if (warm_cnt_q == lat_m1_q) state_next_c = ST_CHECK;
      end
      ST_CHECK: begin
        cmp_c = 1'b1;
        if (chk_cnt_q == LAST_IDX) begin
          last_c       = 1'b1;
          state_next_c = ST_DONE;
        end
      end
      default: state_next_c = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk_In or negedge Rst_In) begin
    if (!Rst_In) begin
      code_q        <= '0;
      lat_m1_q      <= '0;
      warm_cnt_q    <= '0;
      chk_cnt_q     <= '0;
      Busy          <= 1'b0;
      Done          <= 1'b0;
      Pass          <= 1'b0;
      Bad_Instr     <= 1'b0;
      Err_Count     <= '0;
      First_Err_Idx <= '0;
      First_Err_Exp <= '0;
      First_Err_Got <= '0;
      for (int unsigned i = 0; i < MAX_LAT; i++) dline_q[i] <= '0;
    end else if (start_acc_c) begin
      code_q        <= Instruction_In;
      lat_m1_q      <= lat_of(Instruction_In) - LAT_W'(1);
      warm_cnt_q    <= '0;
      chk_cnt_q     <= '0;
      Busy          <= code_ok_c;
      Done          <= !code_ok_c;
      Pass          <= 1'b0;
      Bad_Instr     <= !code_ok_c;
      Err_Count     <= '0;
      First_Err_Idx <= '0;
      First_Err_Exp <= '0;
      First_Err_Got <= '0;
      for (int unsigned i = 0; i < MAX_LAT; i++) dline_q[i] <= '0;
    end else begin
      // Expected value of sample k sits in dline_q[L-1] when its D_Out arrives.
      if (sample_c) begin
        dline_q[0] <= exp_c;
        for (int unsigned i = 1; i < MAX_LAT; i++) dline_q[i] <= dline_q[i-1];
      end
      if (state_q == ST_WARMUP) warm_cnt_q <= warm_cnt_q + LAT_W'(1);
      if (cmp_c) begin
        chk_cnt_q <= chk_cnt_q + CNT_W'(1);
        Err_Count <= err_next_c;
        if (mismatch_c && (Err_Count == '0)) begin
          First_Err_Idx <= chk_cnt_q;
          First_Err_Exp <= exp_dly_c;
          First_Err_Got <= D_Out;
        end
      end
      if (last_c) begin
        Busy <= 1'b0;
        Done <= 1'b1;
        Pass <= (err_next_c == '0);
      end
    end
  end

endmodule

// File: tb/tb_pe_result_checker.sv
// Directed bench for pe_result_checker: ramp stimulus, a well-behaved PE
// stream from closed-form results, injected errors, bad codes, reset, saturation.
module tb_pe_result_checker;
  import pe_chk_pkg::*;

  localparam int unsigned DW   = 16;
  localparam int          NCHK = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start;
  logic          start_sat;
  logic [15:0]   instr;
  logic [DW-1:0] d1, d2, d3, dout, stuck;

  logic          busy, done, pass, bad;
  logic [7:0]    err_cnt;
  logic [7:0]    err_idx;
  logic [DW-1:0] err_exp, err_got;

  logic          s_busy, s_done, s_pass, s_bad;
  logic [7:0]    s_err_cnt;
  logic [9:0]    s_err_idx;
  logic [DW-1:0] s_err_exp, s_err_got;

  int n_total = 0;
  int n_bad   = 0;

  pe_result_checker #(.NUM_CHECKS(16), .CNT_W(8), .DW(16)) u_dut (
    .Clk_In(clk), .Rst_In(rst_n), .Start(start), .Instruction_In(instr),
    .D_In1(d1), .D_In2(d2), .D_In3(d3), .D_Out(dout),
    .Busy(busy), .Done(done), .Pass(pass), .Bad_Instr(bad),
    .Err_Count(err_cnt), .First_Err_Idx(err_idx),
    .First_Err_Exp(err_exp), .First_Err_Got(err_got)
  );

  pe_result_checker #(.NUM_CHECKS(300), .CNT_W(10), .DW(16)) u_sat (
    .Clk_In(clk), .Rst_In(rst_n), .Start(start_sat), .Instruction_In(instr),
    .D_In1(d1), .D_In2(d2), .D_In3(d3), .D_Out(stuck),
    .Busy(s_busy), .Done(s_done), .Pass(s_pass), .Bad_Instr(s_bad),
    .Err_Count(s_err_cnt), .First_Err_Idx(s_err_idx),
    .First_Err_Exp(s_err_exp), .First_Err_Got(s_err_got)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Correct PE result for sample k with d1=k+1, d2=k+4, d3=k+8.
  function automatic logic [15:0] exp_of(input logic [15:0] code, input int k);
    int r;
    case (code)
      F1, F2:  r = k + 1;
      F3:      r = 2 * k + 12;
      F4:      r = (k + 1) * (k + 4);
      F5:      r = (k + 1) + (k + 4) * (k + 8);
      F6:      r = 7 * ((k + 1) * 8 + k * (k + 1) / 2);
      F7:      r = k * k + 1;
      F8:      r = k * (k + 1) * (k + 2) / 3;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic do_run(input logic [15:0] code, input int lat, input int ncyc,
                        input int inj_k, input logic [15:0] inj_val);
    instr = code;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    instr = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == 0) begin
        check_eq($sformatf("F%0d busy_at_start", code), 32'(busy), 32'd1);
        check_eq($sformatf("F%0d done_cleared", code), 32'(done), 32'd0);
      end
      start = (c == 1);
      d1 = 16'(c + 1);
      d2 = 16'(c + 4);
      d3 = 16'(c + 8);
      if (c >= lat) dout = ((c - lat) == inj_k) ? inj_val : exp_of(code, c - lat);
      else          dout = 16'h0;
      if (c == lat + NCHK - 1) check_eq($sformatf("F%0d done_early", code), 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic check_end(input logic [15:0] code, input logic exp_pass, input int exp_err);
    check_eq($sformatf("F%0d done", code), 32'(done), 32'd1);
    check_eq($sformatf("F%0d busy", code), 32'(busy), 32'd0);
    check_eq($sformatf("F%0d pass", code), 32'(pass), 32'(exp_pass));
    check_eq($sformatf("F%0d err_count", code), 32'(err_cnt), 32'(exp_err));
    check_eq($sformatf("F%0d bad_instr", code), 32'(bad), 32'd0);
  endtask

  logic [15:0] ok_code [7] = '{F1, F2, F4, F5, F6, F7, F8};
  int          ok_lat  [7] = '{2, 4, 2, 2, 2, 4, 6};
  logic [15:0] inj_code[3] = '{F3, F8, F7};
  int          inj_lat [3] = '{2, 6, 4};
  int          inj_k   [3] = '{2, 3, 2};
  logic [15:0] inj_exp [3] = '{16'd16, 16'd20, 16'd5};
  logic [15:0] bad_code[2] = '{16'd0, 16'd9};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b1; start = 1'b0; start_sat = 1'b0; instr = '0;
    d1 = '0; d2 = '0; d3 = '0; dout = '0; stuck = 16'hFFFF;
    #2 rst_n = 1'b0;
    #10;
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst done", 32'(done), 32'd0);
    check_eq("rst pass", 32'(pass), 32'd0);
    check_eq("rst bad_instr", 32'(bad), 32'd0);
    check_eq("rst err_count", 32'(err_cnt), 32'd0);
    check_eq("rst sat busy", 32'(s_busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 2; i++) begin
      instr = bad_code[i];
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      instr = '0;
      check_eq($sformatf("code%0d done", bad_code[i]), 32'(done), 32'd1);
      check_eq($sformatf("code%0d bad_instr", bad_code[i]), 32'(bad), 32'd1);
      check_eq($sformatf("code%0d pass", bad_code[i]), 32'(pass), 32'd0);
      check_eq($sformatf("code%0d busy", bad_code[i]), 32'(busy), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check_eq($sformatf("code%0d done_held", bad_code[i]), 32'(done), 32'd1);
    end

    for (int i = 0; i < 7; i++) begin
      do_run(ok_code[i], ok_lat[i], ok_lat[i] + NCHK, -1, 16'h0);
      check_end(ok_code[i], 1'b1, 0);
    end

    for (int i = 0; i < 3; i++) begin
      do_run(inj_code[i], inj_lat[i], inj_lat[i] + NCHK, inj_k[i], 16'h0);
      check_end(inj_code[i], 1'b0, 1);
      check_eq($sformatf("F%0d first_idx", inj_code[i]), 32'(err_idx), 32'(inj_k[i]));
      check_eq($sformatf("F%0d first_exp", inj_code[i]), 32'(err_exp), 32'(inj_exp[i]));
      check_eq($sformatf("F%0d first_got", inj_code[i]), 32'(err_got), 32'd0);
    end

    // Error on the very last compare must already be reflected when Done rises.
    do_run(F4, 2, 2 + NCHK, NCHK - 1, 16'h1234);
    check_end(F4, 1'b0, 1);
    check_eq("F4 last first_idx", 32'(err_idx), 32'(NCHK - 1));
    check_eq("F4 last first_got", 32'(err_got), 32'h1234);

    do_run(F6, 2, 2 + 6, 1, 16'h0);
    check_eq("F6 pre_rst busy", 32'(busy), 32'd1);
    check_eq("F6 pre_rst err_count", 32'(err_cnt), 32'd1);
    check_eq("F6 pre_rst first_exp", 32'(err_exp), 32'd119);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst busy", 32'(busy), 32'd0);
    check_eq("mid_rst err_count", 32'(err_cnt), 32'd0);
    check_eq("mid_rst first_exp", 32'(err_exp), 32'd0);
    check_eq("mid_rst first_idx", 32'(err_idx), 32'd0);
    check_eq("mid_rst done", 32'(done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_run(F6, 2, 2 + NCHK, -1, 16'h0);
    check_end(F6, 1'b1, 0);

    instr = F1;
    start_sat = 1'b1;
    @(posedge clk); #1;
    start_sat = 1'b0;
    instr = '0;
    c = 0;
    while (!s_done && c < 400) begin
      d1 = 16'(c + 1);
      d2 = 16'(c + 4);
      d3 = 16'(c + 8);
      @(posedge clk); #1;
      c++;
    end
    check_eq("sat done", 32'(s_done), 32'd1);
    check_eq("sat cycles", 32'(c), 32'd302);
    check_eq("sat err_count", 32'(s_err_cnt), 32'd255);
    check_eq("sat first_idx", 32'(s_err_idx), 32'd0);
    check_eq("sat first_exp", 32'(s_err_exp), 32'd1);
    check_eq("sat first_got", 32'(s_err_got), 32'hFFFF);
    check_eq("sat pass", 32'(s_pass), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
